// File: rtl/wb_mem_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module : wb_mem_slave_pkg
// Brief  : Shared types and helpers for the dual-port Wishbone memory slave.
// Rev    : 1.0
// ============================================================================
package wb_mem_slave_pkg;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_WAIT = 2'd1,
    WB_ACK  = 2'd2
  } wb_state_e;

  localparam int CNT_W = 4;

  // Wait-state counts saturate at the counter range.
  function automatic logic [CNT_W-1:0] wait_cnt(input int w);
    if (w > (2**CNT_W) - 1) return {CNT_W{1'b1}};
    else if (w < 0)         return '0;
    else                    return CNT_W'(w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_mem_slave_if.sv
`default_nettype none
// ============================================================================
// Module : wb_mem_slave_if
// Brief  : Data and instruction Wishbone buses between arbiter and memory.
// Rev    : 1.0
// ============================================================================
interface wb_mem_slave_if #(
  parameter int DW = 32,
  parameter int PW = 16
);
  logic          wb_cyc;
  logic          wb_stb;
  logic          wb_we;
  logic [DW-1:0] wb_adr;
  logic [DW-1:0] wb_dat_i;
  logic [DW-1:0] wb_dat_o;
  logic          wb_ack;
  logic          wb_inst_cyc;
  logic          wb_inst_stb;
  logic [PW-1:0] wb_inst_pc;
  logic [DW-1:0] wb_inst_o;
  logic          wb_inst_ack;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_i,
    output wb_inst_cyc, wb_inst_stb, wb_inst_pc,
    input  wb_dat_o, wb_ack, wb_inst_o, wb_inst_ack
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_i,
    input  wb_inst_cyc, wb_inst_stb, wb_inst_pc,
    output wb_dat_o, wb_ack, wb_inst_o, wb_inst_ack
  );
endinterface
`default_nettype wire

// File: rtl/wb_mem_slave_dpram.sv
`default_nettype none
// ============================================================================
// Module : wb_mem_slave_dpram
// Brief  : Word array, one write port and two synchronous read-before-write reads.
// Rev    : 1.0
// ============================================================================
module wb_mem_slave_dpram #(
  parameter int DW = 32,
  parameter int AW = 12
) (
  input  wire logic          clk,
  input  wire logic          i_we,
  input  wire logic [AW-1:0] i_waddr,
  input  wire logic [DW-1:0] i_wdata,
  input  wire logic [AW-1:0] i_raddr_a,
  output logic      [DW-1:0] o_rdata_a,
  input  wire logic [AW-1:0] i_raddr_b,
  output logic      [DW-1:0] o_rdata_b
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rdata_a;
  logic [DW-1:0] r_rdata_b;

  // Non-blocking update: a read on the write edge sees the old word.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_rdata_a <= r_mem[i_raddr_a];
    r_rdata_b <= r_mem[i_raddr_b];
  end

  assign o_rdata_a = r_rdata_a;
  assign o_rdata_b = r_rdata_b;

endmodule
`default_nettype wire

// File: rtl/wb_mem_slave.sv
`default_nettype none
// ============================================================================
// Module : wb_mem_slave
// Brief  : Shared program/data memory; R/W data port and read-only inst port.
// Rev    : 1.0
// ============================================================================
module wb_mem_slave
  import wb_mem_slave_pkg::*;
#(
  parameter int DW        = 32,
  parameter int PW        = 16,
  parameter int MEM_AW    = 12,
  parameter int WAIT_DATA = 1,
  parameter int WAIT_INST = 0
) (
  input wire logic       clk,
  input wire logic       rst,
  wb_mem_slave_if.slave  wb
);

  localparam logic [CNT_W-1:0] c_WAIT_D = wait_cnt(WAIT_DATA);
  localparam logic [CNT_W-1:0] c_WAIT_I = wait_cnt(WAIT_INST);

  wb_state_e         r_d_state, r_i_state;
  logic [CNT_W-1:0]  r_d_cnt, r_i_cnt;
  logic [MEM_AW-1:0] r_d_addr, r_i_addr;
  logic              r_d_we, r_d_oor, r_i_oor;
  logic [DW-1:0]     r_d_wdata, r_d_hold, r_i_hold;
  logic              r_d_ack, r_i_ack;

  logic              w_d_req, w_i_req, w_we;
  logic [MEM_AW-1:0] w_raddr_a, w_raddr_b;
  logic [DW-1:0]     w_rdata_a, w_rdata_b, w_d_rd, w_i_rd;

  assign w_d_req = wb.wb_cyc & wb.wb_stb;
  assign w_i_req = wb.wb_inst_cyc & wb.wb_inst_stb;

  // In IDLE the live address is read so a zero-wait access has data on ACK entry.
  assign w_raddr_a = (r_d_state == WB_IDLE) ? wb.wb_adr[MEM_AW-1:0] : r_d_addr;
  assign w_raddr_b = (r_i_state == WB_IDLE) ? wb.wb_inst_pc[MEM_AW-1:0] : r_i_addr;
  assign w_we      = (r_d_state == WB_ACK) & r_d_we & ~r_d_oor;

  wb_mem_slave_dpram #(.DW(DW), .AW(MEM_AW)) u_ram (
    .clk       (clk),
    .i_we      (w_we),
    .i_waddr   (r_d_addr),
    .i_wdata   (r_d_wdata),
    .i_raddr_a (w_raddr_a),
    .o_rdata_a (w_rdata_a),
    .i_raddr_b (w_raddr_b),
    .o_rdata_b (w_rdata_b)
  );

  assign w_d_rd = r_d_oor ? '0 : w_rdata_a;
  assign w_i_rd = r_i_oor ? '0 : w_rdata_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_d_state <= WB_IDLE;
      r_d_cnt   <= '0;
      r_d_addr  <= '0;
      r_d_we    <= 1'b0;
      r_d_oor   <= 1'b0;
      r_d_wdata <= '0;
      r_d_hold  <= '0;
      r_d_ack   <= 1'b0;
    end else begin
      r_d_ack <= 1'b0;
      case (r_d_state)
        WB_IDLE: if (w_d_req) begin
          r_d_addr  <= wb.wb_adr[MEM_AW-1:0];
          r_d_oor   <= |wb.wb_adr[DW-1:MEM_AW];
          r_d_we    <= wb.wb_we;
          r_d_wdata <= wb.wb_dat_i;
          r_d_cnt   <= c_WAIT_D;
          if (c_WAIT_D == '0) begin
            r_d_state <= WB_ACK;
            r_d_ack   <= 1'b1;
          end else begin
            r_d_state <= WB_WAIT;
          end
        end
        WB_WAIT: begin
          r_d_cnt <= r_d_cnt - 1'b1;
          if (!w_d_req) begin
            r_d_state <= WB_IDLE;
          end else if (r_d_cnt == CNT_W'(1)) begin
            r_d_state <= WB_ACK;
            r_d_ack   <= 1'b1;
          end
        end
        WB_ACK: begin
          r_d_state <= WB_IDLE;
          if (!r_d_we) r_d_hold <= w_d_rd;
        end
        default: r_d_state <= WB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_i_state <= WB_IDLE;
      r_i_cnt   <= '0;
      r_i_addr  <= '0;
      r_i_oor   <= 1'b0;
      r_i_hold  <= '0;
      r_i_ack   <= 1'b0;
    end else begin
      r_i_ack <= 1'b0;
      case (r_i_state)
        WB_IDLE: if (w_i_req) begin
          r_i_addr <= wb.wb_inst_pc[MEM_AW-1:0];
          r_i_oor  <= |wb.wb_inst_pc[PW-1:MEM_AW];
          r_i_cnt  <= c_WAIT_I;
          if (c_WAIT_I == '0) begin
            r_i_state <= WB_ACK;
            r_i_ack   <= 1'b1;
          end else begin
            r_i_state <= WB_WAIT;
          end
        end
        WB_WAIT: begin
          r_i_cnt <= r_i_cnt - 1'b1;
          if (!w_i_req) begin
            r_i_state <= WB_IDLE;
          end else if (r_i_cnt == CNT_W'(1)) begin
            r_i_state <= WB_ACK;
            r_i_ack   <= 1'b1;
          end
        end
        WB_ACK: begin
          r_i_state <= WB_IDLE;
          r_i_hold  <= w_i_rd;
        end
        default: r_i_state <= WB_IDLE;
      endcase
    end
  end

  // Read data comes straight from the RAM register during ACK, then from the hold copy.
  assign wb.wb_dat_o    = (r_d_state == WB_ACK && !r_d_we) ? w_d_rd : r_d_hold;
  assign wb.wb_inst_o   = (r_i_state == WB_ACK) ? w_i_rd : r_i_hold;
  assign wb.wb_ack      = r_d_ack;
  assign wb.wb_inst_ack = r_i_ack;

endmodule
`default_nettype wire

// File: tb/tb_wb_mem_slave.sv
`default_nettype none
// ============================================================================
// Module : tb_wb_mem_slave
// Brief  : Self-checking bench; u0 (WAIT_DATA=1, WAIT_INST=0), u1 (3, 2).
// Rev    : 1.0
// ============================================================================
module tb_wb_mem_slave;

  localparam int c_WD0 = 1;
  localparam int c_WI0 = 0;
  localparam int c_WD1 = 3;
  localparam int c_WI1 = 2;

  logic clk;
  logic rst;

  wb_mem_slave_if #(.DW(32), .PW(16)) if0 ();
  wb_mem_slave_if #(.DW(32), .PW(16)) if1 ();

  wb_mem_slave #(.DW(32), .PW(16), .MEM_AW(12), .WAIT_DATA(c_WD0), .WAIT_INST(c_WI0))
    u0 (.clk(clk), .rst(rst), .wb(if0));
  wb_mem_slave #(.DW(32), .PW(16), .MEM_AW(12), .WAIT_DATA(c_WD1), .WAIT_INST(c_WI1))
    u1 (.clk(clk), .rst(rst), .wb(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] dq[$];
  logic [31:0] iq[$];
  logic [31:0] last_rd = '0;

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboards for u0: every ack pops the value queued when its request was driven.
  always @(negedge clk) begin
    if (if0.wb_ack) begin
      if (dq.size() == 0) chk("d_unexpected_ack", 32'd1, 32'd0);
      else chk("d_sb_dat_o", if0.wb_dat_o, dq.pop_front());
    end
    if (if0.wb_inst_ack) begin
      if (iq.size() == 0) chk("i_unexpected_ack", 32'd1, 32'd0);
      else chk("i_sb_inst_o", if0.wb_inst_o, iq.pop_front());
    end
  end

  task automatic d_xfer(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [31:0] exp);
    int n;
    @(posedge clk); #1;
    if0.wb_cyc = 1'b1; if0.wb_stb = 1'b1; if0.wb_we = we;
    if0.wb_adr = adr;  if0.wb_dat_i = dat;
    if (we) dq.push_back(last_rd);
    else begin dq.push_back(exp); last_rd = exp; end
    n = 0;
    do begin @(negedge clk); n++; end while (!if0.wb_ack && n < 20);
    chk("d_latency", n, c_WD0 + 2);
    @(posedge clk); #1;
    if0.wb_cyc = 1'b0; if0.wb_stb = 1'b0; if0.wb_we = 1'b0;
    @(negedge clk);
    chk("d_ack_width", {31'd0, if0.wb_ack}, 32'd0);
  endtask

  task automatic i_fetch(input logic [15:0] pc, input logic [31:0] exp);
    int n;
    @(posedge clk); #1;
    if0.wb_inst_cyc = 1'b1; if0.wb_inst_stb = 1'b1; if0.wb_inst_pc = pc;
    iq.push_back(exp);
    n = 0;
    do begin @(negedge clk); n++; end while (!if0.wb_inst_ack && n < 20);
    chk("i_latency", n, c_WI0 + 2);
    @(posedge clk); #1;
    if0.wb_inst_cyc = 1'b0; if0.wb_inst_stb = 1'b0;
  endtask

  task automatic u1_data(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                         output int n, output logic [31:0] rd);
    @(posedge clk); #1;
    if1.wb_cyc = 1'b1; if1.wb_stb = 1'b1; if1.wb_we = we;
    if1.wb_adr = adr;  if1.wb_dat_i = dat;
    n = 0;
    do begin @(negedge clk); n++; end while (!if1.wb_ack && n < 20);
    rd = if1.wb_dat_o;
    @(posedge clk); #1;
    if1.wb_cyc = 1'b0; if1.wb_stb = 1'b0; if1.wb_we = 1'b0;
  endtask

  task automatic u1_fetch(input logic [15:0] pc, output int n, output logic [31:0] rd);
    @(posedge clk); #1;
    if1.wb_inst_cyc = 1'b1; if1.wb_inst_stb = 1'b1; if1.wb_inst_pc = pc;
    n = 0;
    do begin @(negedge clk); n++; end while (!if1.wb_inst_ack && n < 20);
    rd = if1.wb_inst_o;
    @(posedge clk); #1;
    if1.wb_inst_cyc = 1'b0; if1.wb_inst_stb = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [31:0] rd;
    logic        ack_seen;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 32'h0000_0005, 32'h1234_5678, 32'h0};
    vecs[3]  = '{1'b1, 32'h0000_0006, 32'hCAFE_F00D, 32'h0};
    vecs[4]  = '{1'b1, 32'h0000_0007, 32'h0000_0011, 32'h0};
    vecs[5]  = '{1'b1, 32'h0000_0003, 32'h3333_3333, 32'h0};
    vecs[6]  = '{1'b0, 32'h0000_1000, 32'h0,         32'h0};
    vecs[7]  = '{1'b1, 32'h0000_1003, 32'hFFFF_FFFF, 32'h0};
    vecs[8]  = '{1'b0, 32'h0000_0003, 32'h0,         32'h3333_3333};
    vecs[9]  = '{1'b1, 32'h0000_0FFF, 32'hA5A5_A5A5, 32'h0};
    vecs[10] = '{1'b0, 32'h0000_0FFF, 32'h0,         32'hA5A5_A5A5};
    vecs[11] = '{1'b0, 32'h8000_0010, 32'h0,         32'h0};
    vecs[12] = '{1'b0, 32'h0000_0005, 32'h0,         32'h1234_5678};

    rst = 1'b0;
    if0.wb_cyc = 1'b0; if0.wb_stb = 1'b0; if0.wb_we = 1'b0; if0.wb_adr = '0; if0.wb_dat_i = '0;
    if0.wb_inst_cyc = 1'b0; if0.wb_inst_stb = 1'b0; if0.wb_inst_pc = '0;
    if1.wb_cyc = 1'b0; if1.wb_stb = 1'b0; if1.wb_we = 1'b0; if1.wb_adr = '0; if1.wb_dat_i = '0;
    if1.wb_inst_cyc = 1'b0; if1.wb_inst_stb = 1'b0; if1.wb_inst_pc = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack",      {31'd0, if0.wb_ack},      32'd0);
    chk("rst_inst_ack", {31'd0, if0.wb_inst_ack}, 32'd0);
    chk("rst_dat_o",    if0.wb_dat_o,             32'd0);
    chk("rst_inst_o",   if0.wb_inst_o,            32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 13; i++) d_xfer(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].exp);

    i_fetch(16'd5, 32'h1234_5678);

    // Back-to-back fetches with request held: acks two cycles apart.
    @(posedge clk); #1;
    if0.wb_inst_cyc = 1'b1; if0.wb_inst_stb = 1'b1; if0.wb_inst_pc = 16'd5;
    iq.push_back(32'h1234_5678);
    n = 0;
    do begin @(negedge clk); n++; end while (!if0.wb_inst_ack && n < 20);
    chk("b2b_first_lat", n, 2);
    @(posedge clk); #1;
    if0.wb_inst_pc = 16'd6;
    iq.push_back(32'hCAFE_F00D);
    n = 0;
    do begin @(negedge clk); n++; end while (!if0.wb_inst_ack && n < 20);
    chk("b2b_gap", n, 2);
    @(posedge clk); #1;
    if0.wb_inst_cyc = 1'b0; if0.wb_inst_stb = 1'b0;

    // Fetch of word 7 sampled on the same edge the data write to word 7 lands.
    fork
      d_xfer(1'b1, 32'h7, 32'hAAAA_0000, 32'h0);
      begin
        repeat (2) @(posedge clk);
        i_fetch(16'd7, 32'h0000_0011);
      end
    join
    i_fetch(16'd7, 32'hAAAA_0000);
    i_fetch(16'h1005, 32'h0);

    // u1: preload word 3, then abort a write to it during WAIT.
    u1_data(1'b1, 32'h3, 32'h0BAD_C0DE, n, rd);
    chk("u1_wr_lat", n, c_WD1 + 2);
    @(posedge clk); #1;
    if1.wb_cyc = 1'b1; if1.wb_stb = 1'b1; if1.wb_we = 1'b1;
    if1.wb_adr = 32'h3; if1.wb_dat_i = 32'hFFFF_0000;
    ack_seen = 1'b0;
    repeat (2) begin @(negedge clk); ack_seen |= if1.wb_ack; end
    @(posedge clk); #1;
    if1.wb_cyc = 1'b0; if1.wb_stb = 1'b0; if1.wb_we = 1'b0;
    @(negedge clk); ack_seen |= if1.wb_ack;
    chk("abort_no_ack", {31'd0, ack_seen}, 32'd0);
    u1_data(1'b0, 32'h3, 32'h0, n, rd);
    chk("abort_idle_lat", n, c_WD1 + 2);
    chk("abort_word3",    rd, 32'h0BAD_C0DE);

    u1_fetch(16'd3, n, rd);
    chk("u1_fetch_lat", n, c_WI1 + 2);
    chk("u1_fetch_dat", rd, 32'h0BAD_C0DE);

    // Asynchronous reset while the u1 fetch is in WAIT.
    @(posedge clk); #1;
    if1.wb_inst_cyc = 1'b1; if1.wb_inst_stb = 1'b1; if1.wb_inst_pc = 16'd3;
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("arst_inst_ack", {31'd0, if1.wb_inst_ack}, 32'd0);
    chk("arst_inst_o",   if1.wb_inst_o,            32'd0);
    chk("arst_dat_o",    if1.wb_dat_o,             32'd0);
    chk("arst_u0_dat_o", if0.wb_dat_o,             32'd0);
    last_rd = '0;
    @(posedge clk); #1;
    if1.wb_inst_cyc = 1'b0; if1.wb_inst_stb = 1'b0;
    @(negedge clk);
    chk("arst_hold_ack", {31'd0, if1.wb_inst_ack}, 32'd0);
    rst = 1'b1;
    u1_fetch(16'd3, n, rd);
    chk("post_rst_lat", n, c_WI1 + 2);
    chk("post_rst_dat", rd, 32'h0BAD_C0DE);

    repeat (3) @(posedge clk);
    chk("dq_drained", dq.size(), 32'd0);
    chk("iq_drained", iq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
